// File: rtl/alu_pkg.sv
// Shared ALU opcodes, flag bit positions and arbiter state encodings.
// Pure declarations; no latency or flow control of its own.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OPW   = 3;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;

    // flags vector is {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Two-requester ALU bus: request and response valid/ready channels per port.
// master = requesters, slave = arbiter.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [OPW-1:0]   req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_data;
    logic [3:0]       rsp0_flags;

    logic             req1_valid;
    logic             req1_ready;
    logic [OPW-1:0]   req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_data;
    logic [3:0]       rsp1_flags;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_data, rsp0_flags,
        input  req1_ready, rsp1_valid, rsp1_data, rsp1_flags
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_data, rsp0_flags,
        output req1_ready, rsp1_valid, rsp1_data, rsp1_flags
    );

endinterface

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU producing result and {N,Z,C,V}.
// Zero latency, no flow control; illegal opcodes return 0 with Z and V set.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic [3:0]       flags
);

    logic [WIDTH:0] sum;
    logic           c;
    logic           v;
    logic           illegal;

    always_comb begin
        sum     = '0;
        r       = '0;
        c       = 1'b0;
        v       = 1'b0;
        illegal = 1'b0;
        case (op)
            ALU_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                // carry out of a + ~b + 1 is the inverted borrow
                sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLT: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: illegal = 1'b1;
        endcase

        flags = '0;
        if (illegal) begin
            flags[FLAG_Z] = 1'b1;
            flags[FLAG_V] = 1'b1;
        end else begin
            flags[FLAG_N] = r[WIDTH-1];
            flags[FLAG_Z] = (r == '0);
            flags[FLAG_C] = c;
            flags[FLAG_V] = v;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one registered ALU between two requesters (IDLE->EXEC->RESP).
// Response valid two cycles after the accept cycle; result held until the owner takes it.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input logic                clk,
    input logic                rst_n,
    alu_share_arbiter_if.slave bus
);

    state_t           state_q, state_d;
    logic             rr_ptr_q;
    logic             owner_q;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       flags_q;

    logic             gnt_id;
    logic             accept;
    logic             rsp_fire;
    logic [WIDTH-1:0] alu_r;
    logic [3:0]       alu_flags;

    // a lone requester wins outright; a tie goes to the round-robin pointer
    assign gnt_id = (bus.req0_valid && bus.req1_valid) ? rr_ptr_q : bus.req1_valid;

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        rsp_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    accept  = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = S_RESP;
            S_RESP: begin
                rsp_fire = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
                if (rsp_fire) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ready is masked while reset is held so nothing looks accepted during reset
    assign bus.req0_ready = rst_n && accept && !gnt_id;
    assign bus.req1_ready = rst_n && accept &&  gnt_id;

    assign bus.rsp0_valid = (state_q == S_RESP) && !owner_q;
    assign bus.rsp1_valid = (state_q == S_RESP) &&  owner_q;
    assign bus.rsp0_data  = res_q;
    assign bus.rsp1_data  = res_q;
    assign bus.rsp0_flags = flags_q;
    assign bus.rsp1_flags = flags_q;

    alu_core #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu_core (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .r     (alu_r),
        .flags (alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= 1'b0;
            owner_q  <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= gnt_id;
                op_q    <= gnt_id ? bus.req1_op : bus.req0_op;
                a_q     <= gnt_id ? bus.req1_a  : bus.req0_a;
                b_q     <= gnt_id ? bus.req1_b  : bus.req0_b;
            end
            if (state_q == S_EXEC) begin
                res_q   <= alu_r;
                flags_q <= alu_flags;
            end
            if (rsp_fire) rr_ptr_q <= ~owner_q;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: arithmetic, latency, fairness, backpressure, reset.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(32), .OPW(3)) bus ();

    alu_share_arbiter #(.WIDTH(32), .OPW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction
    function automatic logic rvld(input int p);
        return (p == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    endfunction
    function automatic logic [31:0] rdat(input int p);
        return (p == 0) ? bus.rsp0_data : bus.rsp1_data;
    endfunction
    function automatic logic [3:0] rflg(input int p);
        return (p == 0) ? bus.rsp0_flags : bus.rsp1_flags;
    endfunction

    // single-port operation; checks accept, EXEC gap, valid at accept+2, result and release
    task automatic do_op(input string tag, input int p, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic [3:0] exp_f);
        int n;
        @(negedge clk);
        set_req(p, 1'b1, op, a, b);
        #1;
        n = 0;
        while (!rdy(p) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, "_accept"}, {31'b0, rdy(p)}, 32'd1);
        @(negedge clk);
        set_req(p, 1'b0, op, a, b);
        #1;
        chk({tag, "_exec_vld"}, {31'b0, rvld(p)}, 32'd0);
        @(negedge clk); #1;
        chk({tag, "_vld"},   {31'b0, rvld(p)}, 32'd1);
        chk({tag, "_data"},  rdat(p), exp_d);
        chk({tag, "_flags"}, {28'b0, rflg(p)}, {28'b0, exp_f});
        @(negedge clk); #1;
        chk({tag, "_release"}, {31'b0, rvld(p)}, 32'd0);
    endtask

    initial begin
        int g;
        int nr;
        int cyc;
        int grants [4];

        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        set_req(0, 1'b1, ALU_ADD, 32'h1, 32'h2);
        set_req(1, 1'b1, ALU_ADD, 32'h3, 32'h4);

        // reset with both requesters active
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready0", {31'b0, bus.req0_ready}, 32'd0);
        chk("rst_ready1", {31'b0, bus.req1_ready}, 32'd0);
        chk("rst_vld0",   {31'b0, bus.rsp0_valid}, 32'd0);
        chk("rst_vld1",   {31'b0, bus.rsp1_valid}, 32'd0);
        chk("rst_data0",  bus.rsp0_data, 32'h0);
        chk("rst_data1",  bus.rsp1_data, 32'h0);
        chk("rst_flags0", {28'b0, bus.rsp0_flags}, 32'h0);
        chk("rst_flags1", {28'b0, bus.rsp1_flags}, 32'h0);
        @(negedge clk);
        set_req(0, 1'b0, ALU_ADD, 32'h0, 32'h0);
        set_req(1, 1'b0, ALU_ADD, 32'h0, 32'h0);
        rst_n = 1'b1;

        do_op("add_ovf", 0, ALU_ADD, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 4'b1001);
        do_op("slt",     1, ALU_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000);
        do_op("xor",     0, ALU_XOR, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h00000000, 4'b0100);
        do_op("or",      1, ALU_OR,  32'h80000000, 32'h00000001, 32'h80000001, 4'b1000);

        // fairness: both ports request continuously
        g = 0; nr = 0; cyc = 0;
        @(negedge clk);
        set_req(0, 1'b1, ALU_AND, 32'h01010101, 32'hFFFFFFFF);
        set_req(1, 1'b1, ALU_SUB, 32'h00000001, 32'hF0000000);
        while (nr < 4 && cyc < 60) begin
            #1;
            if (bus.req0_ready && g < 4) begin grants[g] = 0; g++; end
            else if (bus.req1_ready && g < 4) begin grants[g] = 1; g++; end
            if (bus.rsp0_valid) begin
                chk("fair_data0",  bus.rsp0_data, 32'h01010101);
                chk("fair_flags0", {28'b0, bus.rsp0_flags}, 32'h0);
                nr++;
            end
            if (bus.rsp1_valid) begin
                chk("fair_data1",  bus.rsp1_data, 32'h10000001);
                chk("fair_flags1", {28'b0, bus.rsp1_flags}, 32'h0);
                nr++;
            end
            @(negedge clk);
            cyc++;
            if (g == 4) begin
                set_req(0, 1'b0, ALU_AND, 32'h0, 32'h0);
                set_req(1, 1'b0, ALU_SUB, 32'h0, 32'h0);
            end
        end
        chk("fair_rsp_count", nr, 32'd4);
        chk("fair_gnt0", grants[0], 32'd0);
        chk("fair_gnt1", grants[1], 32'd1);
        chk("fair_gnt2", grants[2], 32'd0);
        chk("fair_gnt3", grants[3], 32'd1);

        // backpressure on port 1 while port 0 waits
        bus.rsp1_ready = 1'b0;
        set_req(1, 1'b1, ALU_SUB, 32'h90000000, 32'h80000000);
        #1;
        chk("bp_accept1", {31'b0, bus.req1_ready}, 32'd1);
        @(negedge clk);
        set_req(1, 1'b0, ALU_SUB, 32'h0, 32'h0);
        set_req(0, 1'b1, ALU_OR, 32'h00FF0000, 32'h000000FF);
        #1;
        chk("bp_exec_ready0", {31'b0, bus.req0_ready}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_vld1",   {31'b0, bus.rsp1_valid}, 32'd1);
            chk("bp_data1",  bus.rsp1_data, 32'h10000000);
            chk("bp_flags1", {28'b0, bus.rsp1_flags}, 32'h2);
            chk("bp_ready0", {31'b0, bus.req0_ready}, 32'd0);
            @(negedge clk);
        end
        bus.rsp1_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_after_ready0", {31'b0, bus.req0_ready}, 32'd1);
        chk("bp_after_vld1",   {31'b0, bus.rsp1_valid}, 32'd0);
        @(negedge clk);
        set_req(0, 1'b0, ALU_OR, 32'h0, 32'h0);
        @(negedge clk); #1;
        chk("bp_or_vld0",   {31'b0, bus.rsp0_valid}, 32'd1);
        chk("bp_or_data0",  bus.rsp0_data, 32'h00FF00FF);
        chk("bp_or_flags0", {28'b0, bus.rsp0_flags}, 32'h0);

        // illegal opcode, then a tie must go to port 0
        do_op("illegal", 1, 3'd7, 32'h12345678, 32'h00000009, 32'h0, 4'b0101);
        @(negedge clk);
        set_req(0, 1'b1, ALU_ADD, 32'h1, 32'h1);
        set_req(1, 1'b1, ALU_ADD, 32'h2, 32'h2);
        #1;
        chk("post_ill_ready0", {31'b0, bus.req0_ready}, 32'd1);
        chk("post_ill_ready1", {31'b0, bus.req1_ready}, 32'd0);
        @(negedge clk);
        set_req(0, 1'b0, ALU_ADD, 32'h0, 32'h0);
        set_req(1, 1'b0, ALU_ADD, 32'h0, 32'h0);
        @(negedge clk); #1;
        chk("post_ill_data0", bus.rsp0_data, 32'h2);
        @(negedge clk);

        // reset pulse while an op is executing
        set_req(0, 1'b1, ALU_ADD, 32'h5, 32'h5);
        set_req(1, 1'b1, ALU_ADD, 32'h6, 32'h6);
        #1;
        chk("rr_pre_ready1", {31'b0, bus.req1_ready}, 32'd1);
        @(negedge clk);
        set_req(0, 1'b0, ALU_ADD, 32'h0, 32'h0);
        set_req(1, 1'b0, ALU_ADD, 32'h0, 32'h0);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("mid_rst_vld0", {31'b0, bus.rsp0_valid}, 32'd0);
            chk("mid_rst_vld1", {31'b0, bus.rsp1_valid}, 32'd0);
        end
        @(negedge clk);
        set_req(0, 1'b1, ALU_ADD, 32'h5, 32'h5);
        set_req(1, 1'b1, ALU_ADD, 32'h6, 32'h6);
        #1;
        chk("mid_rst_ready0", {31'b0, bus.req0_ready}, 32'd1);
        chk("mid_rst_ready1", {31'b0, bus.req1_ready}, 32'd0);
        @(negedge clk);
        set_req(0, 1'b0, ALU_ADD, 32'h0, 32'h0);
        set_req(1, 1'b0, ALU_ADD, 32'h0, 32'h0);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
